// File: rtl/sphere3_seq_driver.sv
// sphere3_seq_driver: walks k over [k_base, k_base+num_points), drives the
// Sphere3 generator handshake one request at a time, and buffers results in a
// 2-entry FIFO presented as a valid/ready stream tagged with k.
module sphere3_seq_driver #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        abort,
    input  logic [31:0] k_base,
    input  logic [31:0] num_points,
    input  logic [1:0]  base_sel0,
    input  logic [1:0]  base_sel1,
    input  logic [1:0]  base_sel2,
    input  logic        gen_ready,
    input  logic        gen_done,
    input  logic [31:0] gen_x,
    input  logic [31:0] gen_y,
    input  logic [31:0] gen_z,
    input  logic [31:0] gen_w,
    output logic        gen_start,
    output logic [31:0] gen_k,
    output logic [1:0]  gen_base_sel0,
    output logic [1:0]  gen_base_sel1,
    output logic [1:0]  gen_base_sel2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic [31:0] out_z,
    output logic [31:0] out_w,
    output logic [31:0] out_k,
    output logic        out_last,
    output logic        busy,
    output logic        seq_done,
    output logic [31:0] issued
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] w;
        logic [31:0] k;
        logic        last;
    } entry_t;

    // Pointers are single bits, so the buffer is exactly two entries deep.
    localparam logic [1:0] FULL = 2'(DEPTH);

    state_t      state, state_nx;
    logic [31:0] k_base_q, num_q;
    entry_t      buf_q [DEPTH];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic [1:0]  occ;
    logic        in_flight, can_issue, pop;
    logic        do_run, start_zero, start_seq, do_issue, do_push, finish;
    entry_t      head;

    // A request counts against buffer space from gen_start until its result lands.
    assign in_flight = (state == WAIT);
    assign occ       = count + {1'b0, in_flight};
    assign can_issue = gen_ready && (occ < FULL);
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign do_run    = start_zero || start_seq;

    assign head      = buf_q[rd_ptr];
    assign out_x     = head.x;
    assign out_y     = head.y;
    assign out_z     = head.z;
    assign out_w     = head.w;
    assign out_k     = head.k;
    assign out_last  = head.last;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and control strobes; abort overrides everything.
    always_comb begin
        state_nx   = state;
        start_zero = 1'b0;
        start_seq  = 1'b0;
        do_issue   = 1'b0;
        do_push    = 1'b0;
        finish     = 1'b0;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        if (num_points == 32'd0) begin
                            start_zero = 1'b1;
                        end else begin
                            start_seq = 1'b1;
                            state_nx  = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (can_issue) begin
                        do_issue = 1'b1;
                        state_nx = WAIT;
                    end
                end
                WAIT: begin
                    if (gen_done) begin
                        do_push  = 1'b1;
                        state_nx = (issued < num_q) ? ISSUE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (count == 2'd0 || (count == 2'd1 && pop)) begin
                        finish   = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Configuration, issue counter and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_base_q      <= '0;
            num_q         <= '0;
            gen_base_sel0 <= '0;
            gen_base_sel1 <= '0;
            gen_base_sel2 <= '0;
            gen_k         <= '0;
            gen_start     <= 1'b0;
            issued        <= '0;
            busy          <= 1'b0;
            seq_done      <= 1'b0;
        end else if (abort) begin
            gen_start <= 1'b0;
            issued    <= '0;
            busy      <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            gen_start <= do_issue;
            seq_done  <= start_zero || finish;
            if (do_run) begin
                k_base_q      <= k_base;
                num_q         <= num_points;
                gen_base_sel0 <= base_sel0;
                gen_base_sel1 <= base_sel1;
                gen_base_sel2 <= base_sel2;
                issued        <= '0;
                busy          <= start_seq;
            end
            if (do_issue) begin
                gen_k  <= k_base_q + issued;
                issued <= issued + 32'd1;
            end
            if (finish) busy <= 1'b0;
        end
    end

    // Result FIFO: push on captured gen_done, pop on stream handshake, flush on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                buf_q[wr_ptr] <= '{x: gen_x, y: gen_y, z: gen_z, w: gen_w,
                                   k: gen_k, last: (issued == num_q)};
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sphere3_seq_driver.sv
// Directed bench for sphere3_seq_driver with a latency-programmable generator model.
module tb_sphere3_seq_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [31:0] k_base = '0, num_points = '0;
    logic [1:0]  bs0 = '0, bs1 = '0, bs2 = '0;
    logic        gen_ready, gen_done;
    logic [31:0] gen_x, gen_y, gen_z, gen_w;
    logic        gen_start, out_valid, out_last, busy, seq_done;
    logic [31:0] gen_k, out_x, out_y, out_z, out_w, out_k, issued;
    logic [1:0]  gsel0, gsel1, gsel2;

    always #5 clk = ~clk;

    sphere3_seq_driver #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort),
        .k_base(k_base), .num_points(num_points),
        .base_sel0(bs0), .base_sel1(bs1), .base_sel2(bs2),
        .gen_ready(gen_ready), .gen_done(gen_done),
        .gen_x(gen_x), .gen_y(gen_y), .gen_z(gen_z), .gen_w(gen_w),
        .gen_start(gen_start), .gen_k(gen_k),
        .gen_base_sel0(gsel0), .gen_base_sel1(gsel1), .gen_base_sel2(gsel2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_w(out_w),
        .out_k(out_k), .out_last(out_last),
        .busy(busy), .seq_done(seq_done), .issued(issued)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference point functions (stand-in for the Sphere3 math, bit-exact).
    function automatic logic [31:0] fx(input logic [31:0] k, input logic [1:0] b);
        return {k[15:0], 16'h0} | {30'h0, b};
    endfunction
    function automatic logic [31:0] fy(input logic [31:0] k, input logic [1:0] b);
        return ~k ^ {30'h0, b};
    endfunction
    function automatic logic [31:0] fz(input logic [31:0] k, input logic [1:0] b);
        return k + 32'h0001_8000 + {30'h0, b};
    endfunction
    function automatic logic [31:0] fw(input logic [31:0] k, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] c);
        return k ^ {a, b, c, 26'h0};
    endfunction

    // Generator model: busy for gm_lat cycles after gen_start, then a one-cycle done.
    int          gm_lat = 3;
    logic        gm_hold = 1'b0, stray = 1'b0;
    logic        gm_busy, gm_done;
    int          gm_cnt;
    logic [31:0] gm_k;
    logic [1:0]  gm_b0, gm_b1, gm_b2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gm_busy <= 1'b0; gm_done <= 1'b0; gm_cnt <= 0; gm_k <= '0;
            gm_b0 <= '0; gm_b1 <= '0; gm_b2 <= '0;
            gen_x <= '0; gen_y <= '0; gen_z <= '0; gen_w <= '0;
        end else begin
            gm_done <= 1'b0;
            if (gm_busy) begin
                if (gm_cnt <= 1) begin
                    gm_busy <= 1'b0;
                    gm_done <= 1'b1;
                    gen_x   <= fx(gm_k, gm_b0);
                    gen_y   <= fy(gm_k, gm_b1);
                    gen_z   <= fz(gm_k, gm_b2);
                    gen_w   <= fw(gm_k, gm_b0, gm_b1, gm_b2);
                end else begin
                    gm_cnt <= gm_cnt - 1;
                end
            end else if (gen_start) begin
                gm_busy <= 1'b1;
                gm_cnt  <= gm_lat;
                gm_k    <= gen_k;
                gm_b0   <= gsel0; gm_b1 <= gsel1; gm_b2 <= gsel2;
            end
        end
    end

    assign gen_ready = !gm_busy && !gm_hold;
    assign gen_done  = gm_done || stray;

    // Monitor: stream pops, pulse counts and generator direct outputs.
    logic [31:0]  got_k[$], got_x[$], got_y[$], got_z[$], got_w[$];
    logic         got_last[$];
    logic [127:0] gm_q[$];
    int           n_start = 0, n_done = 0;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_k.push_back(out_k); got_x.push_back(out_x); got_y.push_back(out_y);
            got_z.push_back(out_z); got_w.push_back(out_w); got_last.push_back(out_last);
        end
        if (gm_done) gm_q.push_back({gen_x, gen_y, gen_z, gen_w});
        if (gen_start) n_start <= n_start + 1;
        if (seq_done)  n_done  <= n_done + 1;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start(input logic [31:0] kb, input logic [31:0] n,
                         input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        k_base = kb; num_points = n; bs0 = a; bs1 = b; bs2 = c;
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n = 0;
        while (n_done == d0 && n < budget) begin tick(); n++; end
        chk({tag, "_seq_done"}, 64'(n_done - d0), 64'd1);
    endtask

    task automatic check_stream(input int b, input logic [31:0] k0, input int n, input string tag);
        logic [31:0] k;
        chk({tag, "_count"}, 64'(got_k.size() - b), 64'(n));
        if (got_k.size() - b == n) begin
            for (int i = 0; i < n; i++) begin
                k = k0 + 32'(i);
                chk($sformatf("%s_k%0d", tag, i), got_k[b+i], k);
                chk($sformatf("%s_x%0d", tag, i), got_x[b+i], fx(k, bs0));
                chk($sformatf("%s_y%0d", tag, i), got_y[b+i], fy(k, bs1));
                chk($sformatf("%s_z%0d", tag, i), got_z[b+i], fz(k, bs2));
                chk($sformatf("%s_w%0d", tag, i), got_w[b+i], fw(k, bs0, bs1, bs2));
                chk($sformatf("%s_last%0d", tag, i), got_last[b+i], (i == n - 1));
            end
        end
    endtask

    initial begin
        int s, d, b, g, n;

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gen_start", gen_start, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_issued", issued, 0);
        chk("rst_gen_k", gen_k, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Basic sequence
        out_ready = 1'b1; s = n_start; d = n_done; b = got_k.size();
        start(32'd0, 32'd3, 2'd0, 2'd1, 2'd2);
        chk("basic_busy", busy, 1);
        tick();
        chk("basic_start_lat", gen_start, 1);
        chk("basic_gen_k", gen_k, 0);
        chk("basic_sel2", gsel2, 2);
        wait_done(d, 300, "basic");
        repeat (3) tick();
        chk("basic_starts", 64'(n_start - s), 3);
        chk("basic_one_done", 64'(n_done - d), 1);
        chk("basic_issued", issued, 3);
        chk("basic_busy_end", busy, 0);
        check_stream(b, 32'd0, 3, "basic");

        // Zero count
        s = n_start;
        start(32'd5, 32'd0, 2'd0, 2'd0, 2'd0);
        chk("zero_seq_done", seq_done, 1);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_seq_done_low", seq_done, 0);
        chk("zero_busy2", busy, 0);
        repeat (3) tick();
        chk("zero_no_start", 64'(n_start - s), 0);

        // Index wrap
        d = n_done; b = got_k.size();
        start(32'hFFFF_FFFF, 32'd2, 2'd1, 2'd1, 2'd1);
        wait_done(d, 300, "wrap");
        check_stream(b, 32'hFFFF_FFFF, 2, "wrap");

        // Backpressure
        out_ready = 1'b0; s = n_start; d = n_done; b = got_k.size();
        start(32'd10, 32'd5, 2'd0, 2'd1, 2'd2);
        repeat (20) tick();
        chk("bp_head_early", out_k, 10);
        chk("bp_head_x", out_x, fx(32'd10, 2'd0));
        repeat (180) tick();
        chk("bp_head_late", out_k, 10);
        chk("bp_valid", out_valid, 1);
        chk("bp_starts", 64'(n_start - s), 2);
        chk("bp_no_pop", 64'(got_k.size() - b), 0);
        chk("bp_busy", busy, 1);
        out_ready = 1'b1;
        wait_done(d, 400, "bp");
        check_stream(b, 32'd10, 5, "bp");

        // Abort with one entry buffered and one computation in flight
        out_ready = 1'b0; gm_lat = 20; s = n_start; d = n_done;
        start(32'd40, 32'd4, 2'd2, 2'd1, 2'd0);
        n = 0;
        while (n_start - s < 2 && n < 200) begin tick(); n++; end
        chk("abort_two_starts", 64'(n_start - s), 2);
        chk("abort_pre_valid", out_valid, 1);
        chk("abort_pre_k", out_k, 40);
        abort = 1'b1; run = 1'b1;
        tick();
        abort = 1'b0; run = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_issued", issued, 0);
        repeat (40) tick();
        chk("abort_late_done", out_valid, 0);
        chk("abort_no_seq_done", 64'(n_done - d), 0);
        chk("abort_run_dropped", 64'(n_start - s), 2);
        gm_lat = 3; out_ready = 1'b1; d = n_done; b = got_k.size();
        start(32'd100, 32'd2, 2'd0, 2'd1, 2'd2);
        wait_done(d, 300, "rerun");
        check_stream(b, 32'd100, 2, "rerun");

        // Stray gen_done in IDLE and in ISSUE
        stray = 1'b1; tick(); stray = 1'b0;
        chk("stray_idle", out_valid, 0);
        tick();
        chk("stray_idle2", out_valid, 0);
        gm_hold = 1'b1; s = n_start; d = n_done; b = got_k.size();
        start(32'd200, 32'd1, 2'd0, 2'd0, 2'd1);
        tick();
        stray = 1'b1; tick(); stray = 1'b0;
        tick();
        chk("stray_issue_valid", out_valid, 0);
        chk("stray_issue_nopush", 64'(got_k.size() - b), 0);
        chk("stray_issue_nostart", 64'(n_start - s), 0);
        gm_hold = 1'b0;
        wait_done(d, 300, "stray");
        check_stream(b, 32'd200, 1, "stray");

        // End-to-end against the generator's direct outputs
        gm_lat = 5; d = n_done; b = got_k.size(); g = gm_q.size();
        start(32'd0, 32'd4, 2'd0, 2'd1, 2'd2);
        wait_done(d, 400, "e2e");
        chk("e2e_gm_count", 64'(gm_q.size() - g), 4);
        if (gm_q.size() - g == 4 && got_k.size() - b == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("e2e_direct%0d", i),
                    {got_x[b+i], got_y[b+i]} ^ {got_z[b+i], got_w[b+i]},
                    gm_q[g+i][127:64] ^ gm_q[g+i][63:0]);
        end
        check_stream(b, 32'd0, 4, "e2e");

        // Asynchronous reset mid-sequence
        gm_lat = 3; out_ready = 1'b0;
        start(32'd7, 32'd5, 2'd1, 2'd2, 2'd0);
        repeat (15) tick();
        chk("arst_pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_issued", issued, 0);
        chk("arst_gen_k", gen_k, 0);
        chk("arst_out_k", out_k, 0);
        chk("arst_sel1", gsel1, 0);
        tick();
        rst = 1'b0;
        s = n_start;
        repeat (5) tick();
        chk("arst_idle_nostart", 64'(n_start - s), 0);
        chk("arst_idle_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
